// File: rtl/fmdll_pkg.sv
// rtl/fmdll_pkg.sv - shared FMDLL constants, FSM encoding and ratio clamp
package fmdll_pkg;

    localparam int CNT_W_DEF = 6;
    localparam int N_MIN     = 4;

    typedef enum logic {
        ST_START = 1'b0,
        ST_RUN   = 1'b1
    } fsm_state_t;

    function automatic int clamp_ratio(input int n);
        return (n < N_MIN) ? N_MIN : n;
    endfunction

endpackage

// File: rtl/hld_clk_div_gen_if.sv
// rtl/hld_clk_div_gen_if.sv - config request and phase/divide outputs of the hold divider
interface hld_clk_div_gen_if
    import fmdll_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic [CNT_W-1:0] n_ratio;
    logic             m_sel;
    logic             ratio_load;
    logic             clk2;
    logic             clk4;
    logic             DIV_M;
    logic             M;
    logic             cfg_ack;
    logic             cfg_pend;

    modport master (
        output n_ratio, m_sel, ratio_load,
        input  clk2, clk4, DIV_M, M, cfg_ack, cfg_pend
    );

    modport slave (
        input  n_ratio, m_sel, ratio_load,
        output clk2, clk4, DIV_M, M, cfg_ack, cfg_pend
    );
endinterface

// File: rtl/hld_cfg_shadow.sv
// rtl/hld_cfg_shadow.sv - pending ratio/mode registers applied only at a divider wrap
module hld_cfg_shadow
    import fmdll_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEF_N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] n_ratio,
    input  logic             m_sel,
    input  logic             ratio_load,
    input  logic             apply,
    output logic [CNT_W-1:0] n_act,
    output logic             m_next,
    output logic             cfg_pend,
    output logic             cfg_ack
);
    localparam logic [CNT_W-1:0] N_DEF_C = CNT_W'(clamp_ratio(DEF_N));

    logic [CNT_W-1:0] n_clamp;
    logic [CNT_W-1:0] n_next;
    logic [CNT_W-1:0] pend_n;
    logic             pend_m;
    logic             m_act;

    // A load coinciding with the apply edge bypasses the pending registers.
    always_comb begin
        n_clamp = (n_ratio < CNT_W'(N_MIN)) ? CNT_W'(N_MIN) : n_ratio;
        n_next  = n_act;
        m_next  = m_act;
        if (apply && ratio_load) begin
            n_next = n_clamp;
            m_next = m_sel;
        end else if (apply && cfg_pend) begin
            n_next = pend_n;
            m_next = pend_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_act    <= N_DEF_C;
            m_act    <= 1'b0;
            pend_n   <= N_DEF_C;
            pend_m   <= 1'b0;
            cfg_pend <= 1'b0;
            cfg_ack  <= 1'b0;
        end else begin
            n_act   <= n_next;
            m_act   <= m_next;
            cfg_ack <= apply && (ratio_load || cfg_pend);
            if (apply) begin
                cfg_pend <= 1'b0;
            end else if (ratio_load) begin
                cfg_pend <= 1'b1;
                pend_n   <= n_clamp;
                pend_m   <= m_sel;
            end
        end
    end
endmodule

// File: rtl/hld_clk_div_gen.sv
// rtl/hld_clk_div_gen.sv - clk2/clk4/DIV_M/M generator for the FMDLL hold-control path
module hld_clk_div_gen
    import fmdll_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DEF_N     = 8,
    parameter int START_CYC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    hld_clk_div_gen_if.slave    bus
);
    localparam int SC_W = (START_CYC < 2) ? 1 : $clog2(START_CYC + 1);

    fsm_state_t       state;
    logic [SC_W-1:0]  sc_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] n_act;
    logic [CNT_W-1:0] n_last;
    logic             m_next;
    logic             wrap;
    logic             start_done;
    logic             apply;
    logic             clk2_q;
    logic             clk4_q;
    logic             div_m_q;
    logic             m_q;

    hld_cfg_shadow #(
        .CNT_W (CNT_W),
        .DEF_N (DEF_N)
    ) u_shadow (
        .clk        (clk),
        .rst_n      (rst_n),
        .n_ratio    (bus.n_ratio),
        .m_sel      (bus.m_sel),
        .ratio_load (bus.ratio_load),
        .apply      (apply),
        .n_act      (n_act),
        .m_next     (m_next),
        .cfg_pend   (bus.cfg_pend),
        .cfg_ack    (bus.cfg_ack)
    );

    // Config is applied both at a RUN wrap and on the START->RUN entry edge.
    always_comb begin
        n_last     = n_act - CNT_W'(1);
        wrap       = (state == ST_RUN) && (cnt == n_last);
        start_done = (state == ST_START) && (sc_cnt == SC_W'(START_CYC));
        apply      = wrap || start_done;
        cnt_nxt    = ((state == ST_RUN) && !wrap) ? cnt + CNT_W'(1) : '0;
    end

    // Outputs are computed from cnt_nxt so they line up with the registered cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_START;
            sc_cnt  <= '0;
            cnt     <= '0;
            clk2_q  <= 1'b0;
            clk4_q  <= 1'b0;
            div_m_q <= 1'b0;
            m_q     <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            case (state)
                ST_START: begin
                    if (start_done) begin
                        state <= ST_RUN;
                        m_q   <= m_next;
                    end else begin
                        sc_cnt <= sc_cnt + SC_W'(1);
                    end
                end
                ST_RUN: begin
                    clk2_q  <= cnt_nxt[0];
                    clk4_q  <= cnt_nxt[1];
                    div_m_q <= (cnt_nxt == n_last);
                    m_q     <= m_next;
                end
            endcase
        end
    end

    assign bus.clk2  = clk2_q;
    assign bus.clk4  = clk4_q;
    assign bus.DIV_M = div_m_q;
    assign bus.M     = m_q;
endmodule

// File: tb/tb_hld_clk_div_gen.sv
// tb/tb_hld_clk_div_gen.sv - scoreboard bench for hld_clk_div_gen
module tb_hld_clk_div_gen;

    typedef struct {int cyc; logic m;} div_exp_t;
    typedef struct {int cyc; logic [5:0] val;} probe_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hld_clk_div_gen_if #(.CNT_W(6)) bus_if ();

    hld_clk_div_gen #(
        .CNT_W     (6),
        .DEF_N     (8),
        .START_CYC (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // cyc is the index of the cycle following each edge; the release edge starts cycle 0
    int cyc = -1;
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : -1;

    div_exp_t q_div[$];
    int       q_ack[$];
    probe_t   q_probe[$];
    int       checks = 0;
    int       errors = 0;
    int       tmo_cnt = 0;
    bit       sb_en = 1'b1;
    bit       done = 1'b0;
    logic     prev_clk2 = 1'b0;
    logic     prev_clk4 = 1'b0;

    function automatic void push_div(input int c, input logic m);
        div_exp_t e;
        e.cyc = c;
        e.m   = m;
        q_div.push_back(e);
    endfunction

    // val = {clk2, clk4, DIV_M, M, cfg_ack, cfg_pend}
    function automatic void push_probe(input int c, input logic [5:0] v);
        probe_t p;
        p.cyc = c;
        p.val = v;
        q_probe.push_back(p);
    endfunction

    task automatic wait_cyc(input int k);
        int g = 0;
        @(negedge clk);
        while (cyc != k && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (cyc != k) tmo_cnt++;
    endtask

    task automatic load_at(input int k, input logic [5:0] n, input logic m);
        wait_cyc(k);
        bus_if.n_ratio    = n;
        bus_if.m_sel      = m;
        bus_if.ratio_load = 1'b1;
        @(negedge clk);
        bus_if.ratio_load = 1'b0;
    endtask

    always @(negedge clk) begin
        div_exp_t   e;
        probe_t     p;
        int         a;
        logic [5:0] obs;
        obs = {bus_if.clk2, bus_if.clk4, bus_if.DIV_M, bus_if.M, bus_if.cfg_ack, bus_if.cfg_pend};
        if (sb_en && bus_if.DIV_M) begin
            checks++;
            if (q_div.size() == 0) begin
                errors++;
                $display("FAIL div_m_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                e = q_div.pop_front();
                if (e.cyc != cyc || e.m !== bus_if.M) begin
                    errors++;
                    $display("FAIL div_m: got cycle %0d M=%0b, expected cycle %0d M=%0b", cyc, bus_if.M, e.cyc, e.m);
                end
            end
        end
        if (sb_en && bus_if.cfg_ack) begin
            checks++;
            if (q_ack.size() == 0) begin
                errors++;
                $display("FAIL cfg_ack_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                a = q_ack.pop_front();
                if (a != cyc) begin
                    errors++;
                    $display("FAIL cfg_ack: got cycle %0d, expected cycle %0d", cyc, a);
                end
            end
        end
        if (q_probe.size() != 0 && q_probe[0].cyc == cyc) begin
            p = q_probe.pop_front();
            checks++;
            if (obs !== p.val) begin
                errors++;
                $display("FAIL probe cycle %0d: got {clk2,clk4,DIV_M,M,ack,pend}=%b, expected %b", cyc, obs, p.val);
            end
        end
        if (rst_n && bus_if.clk2 && !prev_clk2) begin
            checks++;
            if (bus_if.clk4 !== prev_clk4) begin
                errors++;
                $display("FAIL phase cycle %0d: clk4 changed to %0b while clk2 rose, expected %0b", cyc, bus_if.clk4, prev_clk4);
            end
        end
        prev_clk2 <= bus_if.clk2;
        prev_clk4 <= bus_if.clk4;
        if (done) begin
            checks++;
            if (q_div.size() != 0) begin
                errors++;
                $display("FAIL div_m_missing: %0d pulses outstanding, expected 0", q_div.size());
            end
            checks++;
            if (q_ack.size() != 0) begin
                errors++;
                $display("FAIL cfg_ack_missing: %0d acks outstanding, expected 0", q_ack.size());
            end
            checks++;
            if (q_probe.size() != 0) begin
                errors++;
                $display("FAIL probe_missing: %0d probes outstanding, expected 0", q_probe.size());
            end
            checks++;
            if (tmo_cnt != 0) begin
                errors++;
                $display("FAIL timeout: %0d waits expired, expected 0", tmo_cnt);
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        bus_if.n_ratio    = 6'd0;
        bus_if.m_sel      = 1'b0;
        bus_if.ratio_load = 1'b0;

        push_probe(-1, 6'b000000);
        push_probe(0,  6'b000000);
        push_probe(1,  6'b000000);
        push_probe(2,  6'b000000);
        push_probe(3,  6'b100000);
        push_probe(4,  6'b010000);
        push_probe(5,  6'b110000);
        push_probe(9,  6'b111000);
        push_probe(30, 6'b000001);
        push_probe(33, 6'b111001);
        push_probe(34, 6'b000110);
        push_probe(56, 6'b001000);
        push_probe(57, 6'b000000);
        push_probe(60, 6'b110001);
        push_probe(62, 6'b000010);
        push_probe(73, 6'b111000);
        push_probe(74, 6'b000110);
        push_probe(85, 6'b000101);
        push_probe(88, 6'b000010);
        push_probe(99, 6'b111000);
        push_probe(104, 6'b000001);
        foreach (q_ack[i]) q_ack.delete(i);
        q_ack.push_back(34);
        q_ack.push_back(52);
        q_ack.push_back(62);
        q_ack.push_back(74);
        q_ack.push_back(88);
        push_div(9, 1'b0);  push_div(17, 1'b0); push_div(25, 1'b0); push_div(33, 1'b0);
        push_div(39, 1'b1); push_div(45, 1'b1); push_div(51, 1'b1);
        push_div(56, 1'b0); push_div(61, 1'b0);
        push_div(65, 1'b0); push_div(69, 1'b0); push_div(73, 1'b0);
        push_div(80, 1'b1); push_div(87, 1'b1);
        push_div(99, 1'b0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        load_at(29, 6'd6, 1'b1);
        load_at(47, 6'd5, 1'b0);
        load_at(58, 6'd2, 1'b0);
        load_at(73, 6'd7, 1'b1);
        load_at(82, 6'd10, 1'b0);
        load_at(84, 6'd12, 1'b0);
        load_at(102, 6'd9, 1'b1);

        // reset lands mid-cycle 105 (cnt=5) with a config pending
        wait_cyc(104);
        push_probe(105, 6'b000000);
        @(posedge clk);
        #2 rst_n = 1'b0;
        push_probe(-1, 6'b000000);
        push_probe(2,  6'b000000);
        push_probe(3,  6'b100000);
        push_probe(4,  6'b010000);
        push_probe(9,  6'b111000);
        push_probe(10, 6'b000000);
        push_div(9, 1'b0); push_div(17, 1'b0); push_div(25, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        wait_cyc(26);
        sb_en = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) begin
                bus_if.n_ratio    = 6'($urandom_range(4, 63));
                bus_if.m_sel      = 1'($urandom_range(0, 1));
                bus_if.ratio_load = 1'b1;
            end else begin
                bus_if.ratio_load = 1'b0;
            end
        end
        bus_if.ratio_load = 1'b0;
        done = 1'b1;
    end

endmodule

// File: doc/hld_clk_div_gen.md
# hld_clk_div_gen

Programmable phase/divide generator that drives the hold-control path of the FMDLL. Runs on the DCO output clock and produces the `clk2` and `clk4` phase clocks, the once-per-N-cycles `DIV_M` pulse, and the applied mode `M`. These are exactly the signals the hold-control block consumes. Ratio and mode changes are shadowed and applied only at a divider wrap, so the consumer never sees a truncated or glitched period.

## Interface
Parameters:
- `CNT_W`, default 6: width of the ratio and of the cycle counter.
- `DEF_N`, default 8: ratio N loaded at reset.
- `START_CYC`, default 2: number of post-reset cycles with outputs held low.

Ports:
- `clk`  in  1: DCO output clock. This is the single clock domain.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `n_ratio`  in  CNT_W: requested division ratio N. Values below 4 are clamped to 4.
- `m_sel`  in  1: requested mode; 1 selects the `clk4`-only hold path.
- `ratio_load`  in  1: single-cycle strobe that captures `n_ratio` and `m_sel`.
- `clk2`  out  1: cnt bit 0 phase.
- `clk4`  out  1: cnt bit 1 phase.
- `DIV_M`  out  1: high for the single cycle in which cnt == N-1.
- `M`  out  1: applied mode.
- `cfg_ack`  out  1: single-cycle pulse in the first cycle that runs with a new config.
- `cfg_pend`  out  1: high while a captured config is waiting for the next wrap.

## Operation
- FSM states:
  - START: entered on reset. Counts START_CYC cycles, then goes to RUN with cnt=0.
  - RUN: steady state. No other states exist.
- Counter cnt:
  - In RUN: 0 to N_act-1, then wraps to 0.
  - In START: held at 0.
- Outputs are registered and updated on the same edge as cnt. In RUN they hold the following values for the current cnt:
  - `clk2` = cnt[0].
  - `clk4` = cnt[1].
  - `DIV_M` = (cnt == N_act-1).
  - `M` = M_act.
- All outputs are 0 in START.
- Odd N: `clk2` stays 0 for two consecutive cycles across the wrap (N-1, then 0). This is accepted and required. No re-phasing is done.
- `clk4` transitions only in cycles where `clk2` falls, or at the wrap. `clk4` never changes while `clk2` is rising.
- Config shadow:
  - `ratio_load` in any state stores the clamped `n_ratio` and `m_sel` into pending registers and sets `cfg_pend`.
  - A second load before the wrap overwrites the pending values.
- Apply: at the edge where cnt wraps from N_act-1 to 0:
  - If pending is set, N_act and M_act take the pending values, pending is cleared, and `cfg_ack` is 1 in the following cycle.
  - A load sampled in the N_act-1 cycle itself applies at that same wrap.
- A load during START applies on entry to RUN, with `cfg_ack` in the first RUN cycle.
- `rst_n` low mid-operation clears the block immediately:
  - State = START, cnt = 0, N_act = DEF_N (clamped), M_act = 0.
  - Pending cleared, all outputs 0.
- Arithmetic:
  - N_act is held in CNT_W bits.
  - The compare uses N_act-1 computed in CNT_W bits. N_act ≥ 4 guarantees no underflow.

## Timing
- Reset values: `clk2` = `clk4` = `DIV_M` = `M` = `cfg_ack` = 0. `cfg_pend` = 0.
- First RUN cycle comes START_CYC cycles after `rst_n` deasserts (synchronous release edge counted as cycle 0). cnt = 0 in that cycle.
- `DIV_M` period is exactly N_act cycles. Its first assertion is N_act-1 cycles after entry to RUN.
- Config latency:
  - Minimum 1 cycle, for a load in the N_act-1 cycle.
  - Maximum N_act cycles.
- `cfg_pend` rises the cycle after `ratio_load` and falls in the `cfg_ack` cycle.
- `ratio_load` and a wrap in the same cycle: the loaded value is applied at that wrap. No config is lost.

## Structure
- Shared package `fmdll_pkg` holds:
  - The CNT_W default.
  - The minimum-ratio constant N_MIN = 4.
  - The FSM state encoding {START, RUN}.
- One natural sub-module: `hld_cfg_shadow`. It contains the pending registers, the clamp, and the apply handshake, and exposes `cfg_pend` and `cfg_ack`.
- The top level contains the FSM, the counter, and the output registers.

## Test plan
- Reset and start: `rst_n` released, default N=8 → all outputs 0 for 2 cycles.
  - `DIV_M` first high in RUN cycle 7, then every 8 cycles.
  - `clk2` toggles every cycle; `clk4` has period 4.
- Ratio change: `ratio_load` with N=6, `m_sel`=1 at cnt=3 of an N=8 period.
  - The current period completes at 8 cycles.
  - `cfg_ack` is 1 at the next cnt=0; `M`=1 from then on.
  - `DIV_M` then repeats every 6 cycles.
- Odd ratio and clamp:
  - N=5 → `clk2` is 0 at cnt 4 and cnt 0; `DIV_M` period is 5.
  - N=2 → clamped; `DIV_M` period is 4.
- Boundary load:
  - A load in the N-1 cycle applies at that wrap, with `cfg_ack` 1 cycle later.
  - A double load (N=10, then N=12) before the wrap results in only N=12 being applied.
- Mid-operation reset: `rst_n` low at cnt=5 with a config pending.
  - All outputs 0 and `cfg_pend` 0 immediately.
  - After release the block restarts with N=8 and `M`=0.
- Phase check over 1000 cycles with random legal N: `clk4` never changes in a cycle where `clk2` rises.
